// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared state type and constants for the sha256 message padder
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_ZERO = 2'd1,
        ST_LEN  = 2'd2
    } sha256_pad_state_t;

    localparam int          SHA256_BLK_BEATS = 8;
    localparam logic [7:0]  SHA256_PAD_BYTE  = 8'h80;
    localparam int          SHA256_LEN_WIDTH = 64;

endpackage

// File: rtl/sha256_pad_merge.sv
// rtl/sha256_pad_merge.sv - keeps the leading valid bytes of a tail beat and appends the 0x80 pad byte
module sha256_pad_merge
    import sha256_pkg::*;
#(
    parameter int I_WIDTH = 64
) (
    input  logic [I_WIDTH-1:0] data_i,
    input  logic [3:0]         bytes_i,
    output logic [I_WIDTH-1:0] data_o
);

    // bytes_i is already clamped to 0..8; a full beat gets no pad byte here
    always_comb begin
        data_o = '0;
        for (int i = 0; i < I_WIDTH / 8; i++) begin
            if (4'(i) < bytes_i) begin
                data_o[I_WIDTH-1-8*i -: 8] = data_i[I_WIDTH-1-8*i -: 8];
            end else if (4'(i) == bytes_i) begin
                data_o[I_WIDTH-1-8*i -: 8] = SHA256_PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/sha256_pad.sv
// rtl/sha256_pad.sv - SHA-256 message padder and beat sequencer; SHA256_PAD_BYPASS_EN adds in_pad_i for pre-padded messages
module sha256_pad
    import sha256_pkg::*;
#(
    parameter int I_WIDTH   = 64,
    parameter int BLK_BEATS = SHA256_BLK_BEATS
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [I_WIDTH-1:0] in_data_i,
    input  logic [3:0]         in_bytes_i,
    input  logic               in_last_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
`ifdef SHA256_PAD_BYPASS_EN
    input  logic               in_pad_i,
`endif
    output logic [I_WIDTH-1:0] out_data_o,
    output logic [1:0]         out_mode_o,
    output logic               out_last_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    localparam int IW = $clog2(BLK_BEATS);
    localparam int LW = SHA256_LEN_WIDTH;

    sha256_pad_state_t r_state, w_state_nxt;
    logic [IW-1:0]      r_idx;
    logic [LW-1:0]      r_len, w_len_nxt, w_len_add;
    logic               r_first, w_first_nxt;
    logic               r_pad_pend, w_pad_pend_nxt;
    logic [I_WIDTH-1:0] r_out_data, w_gen_data, w_merged;
    logic [1:0]         r_out_mode;
    logic               r_out_last, r_out_valid;
    logic               w_gen_valid, w_gen_last;
    logic               w_load, w_fire, w_acc, w_pad;
    logic [3:0]         w_bytes_c;
    logic [IW-1:0]      w_ld_idx;

    assign w_fire     = r_out_valid && out_ready_i;
    assign w_load     = !r_out_valid || out_ready_i;
    assign in_ready_o = !rst_i && (r_state == ST_DATA) && w_load;
    assign w_acc      = in_valid_i && in_ready_o;
    // block position of the beat being loaded into the output register
    assign w_ld_idx   = r_idx + IW'(w_fire);
    assign w_bytes_c  = (in_bytes_i > 4'd8) ? 4'd8 : in_bytes_i;
    assign w_len_add  = in_last_i ? LW'({w_bytes_c, 3'b000}) : LW'(I_WIDTH);

    assign out_data_o  = r_out_data;
    assign out_mode_o  = r_out_mode;
    assign out_last_o  = r_out_last;
    assign out_valid_o = r_out_valid;

    sha256_pad_merge #(.I_WIDTH(I_WIDTH)) u_merge (
        .data_i  (in_data_i),
        .bytes_i (w_bytes_c),
        .data_o  (w_merged)
    );

`ifdef SHA256_PAD_BYPASS_EN
    logic r_start, r_bypass;

    assign w_pad = r_start ? in_pad_i : !r_bypass;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_start  <= 1'b1;
            r_bypass <= 1'b0;
        end else if (w_acc) begin
            if (r_start) r_bypass <= !in_pad_i;
            r_start <= in_last_i && !w_pad;
        end else if (w_load && r_state == ST_LEN) begin
            r_start <= 1'b1;
        end
    end
`else
    assign w_pad = 1'b1;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_gen_valid    = 1'b0;
        w_gen_data     = '0;
        w_gen_last     = 1'b0;
        w_len_nxt      = r_len;
        w_first_nxt    = r_first;
        w_pad_pend_nxt = r_pad_pend;
        if (w_load) begin
            case (r_state)
                ST_DATA: begin
                    if (w_acc) begin
                        w_gen_valid = 1'b1;
                        w_first_nxt = 1'b0;
                        w_len_nxt   = r_len + w_len_add;
                        if (!w_pad) begin
                            w_gen_data = in_data_i;
                            w_gen_last = in_last_i;
                            if (in_last_i) begin
                                w_first_nxt = 1'b1;
                                w_len_nxt   = '0;
                            end
                        end else if (!in_last_i) begin
                            w_gen_data = in_data_i;
                        end else begin
                            w_gen_data = w_merged;
                            if (w_bytes_c == 4'd8) begin
                                w_pad_pend_nxt = 1'b1;
                                w_state_nxt    = ST_ZERO;
                            end else if (w_ld_idx == IW'(BLK_BEATS - 2)) begin
                                w_state_nxt = ST_LEN;
                            end else begin
                                w_state_nxt = ST_ZERO;
                            end
                        end
                    end
                end
                ST_ZERO: begin
                    w_gen_valid    = 1'b1;
                    w_gen_data     = r_pad_pend ? {SHA256_PAD_BYTE, {(I_WIDTH-8){1'b0}}} : '0;
                    w_pad_pend_nxt = 1'b0;
                    w_first_nxt    = 1'b0;
                    if (w_ld_idx == IW'(BLK_BEATS - 2)) w_state_nxt = ST_LEN;
                end
                ST_LEN: begin
                    w_gen_valid = 1'b1;
                    w_gen_data  = I_WIDTH'(r_len);
                    w_gen_last  = 1'b1;
                    w_len_nxt   = '0;
                    w_first_nxt = 1'b1;
                    w_state_nxt = ST_DATA;
                end
                default: w_state_nxt = ST_DATA;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_DATA;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx       <= '0;
            r_len       <= '0;
            r_first     <= 1'b1;
            r_pad_pend  <= 1'b0;
            r_out_data  <= '0;
            r_out_mode  <= 2'b00;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_fire) r_idx <= r_idx + 1'b1;
            r_len      <= w_len_nxt;
            r_first    <= w_first_nxt;
            r_pad_pend <= w_pad_pend_nxt;
            if (w_load) begin
                r_out_valid <= w_gen_valid;
                if (w_gen_valid) begin
                    r_out_data <= w_gen_data;
                    r_out_mode <= {1'b0, r_first};
                    r_out_last <= w_gen_last;
                end
            end
        end
    end

endmodule
